// File: rtl/mdu_pkg.sv
// mdu_pkg: shared op and FSM state encodings for the
// multiply/divide unit, plus small op decode helpers.
package mdu_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_CALC = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/mdu_negate.sv
// mdu_negate: conditional two's-complement negation.
// Ports: en_i (negate when 1), val_i (N-bit in), val_o (N-bit out).
module mdu_negate #(
    parameter int N = 32
) (
    input  logic         en_i,
    input  logic [N-1:0] val_i,
    output logic [N-1:0] val_o
);

    assign val_o = en_i ? (~val_i + N'(1)) : val_i;

endmodule

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative multiply/divide with in-block HI/LO.
// Ports: clk, rst (async, active low), start/op/src_a/src_b request,
// flush abort, hi_wen/lo_wen/wdata direct writes,
// busy/done/stall status, hi/lo registered results.
module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int          W        = 32,
    parameter logic [W-1:0] HILO_RST = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [W-1:0] src_a,
    input  logic [W-1:0] src_b,
    input  logic         flush,
    input  logic         hi_wen,
    input  logic         lo_wen,
    input  logic [W-1:0] wdata,
    output logic         busy,
    output logic         done,
    output logic         stall,
    output logic [W-1:0] hi,
    output logic [W-1:0] lo
);

    localparam int CW = $clog2(W + 1);

    logic [1:0]     state_q, state_d;
    logic           div_q, sa_q, sb_q, dz_q;
    logic [W-1:0]   m_q;
    logic [2*W-1:0] acc_q, step;
    logic [CW-1:0]  cnt_q;
    logic [W-1:0]   hi_q, lo_q;

    logic           a_neg, b_neg, accept, commit;
    logic [W-1:0]   mag_a, mag_b;
    logic [W:0]     sum, rsh;
    logic [W-1:0]   diff;
    logic           ge;
    logic           p_neg_en, r_neg_en;
    logic [2*W-1:0] res_p;
    logic [W-1:0]   res_r;

    assign a_neg = op_is_signed(op) & src_a[W-1];
    assign b_neg = op_is_signed(op) & src_b[W-1];

    mdu_negate #(.N(W)) u_neg_a (.en_i(a_neg), .val_i(src_a), .val_o(mag_a));
    mdu_negate #(.N(W)) u_neg_b (.en_i(b_neg), .val_i(src_b), .val_o(mag_b));

    // One iteration. Multiply: {HI,LO} holds partial product over the
    // multiplier. Divide: HI is the partial remainder, LO shifts the
    // dividend out and the quotient in.
    always_comb begin
        sum  = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, m_q} : '0);
        rsh  = {acc_q[2*W-1:W], acc_q[W-1]};
        ge   = rsh >= {1'b0, m_q};
        diff = rsh[W-1:0] - m_q;
        step = {sum, acc_q[W-1:1]};
        if (div_q) begin
            step = ge ? {diff, acc_q[W-2:0], 1'b1}
                      : {rsh[W-1:0], acc_q[W-2:0], 1'b0};
        end
    end

    // Divide by zero keeps the all-ones quotient un-negated.
    assign p_neg_en = (sa_q ^ sb_q) & ~(div_q & dz_q);
    assign r_neg_en = div_q & sa_q;

    mdu_negate #(.N(2*W)) u_neg_p (.en_i(p_neg_en), .val_i(acc_q), .val_o(res_p));
    mdu_negate #(.N(W)) u_neg_r (.en_i(r_neg_en), .val_i(acc_q[2*W-1:W]), .val_o(res_r));

    assign accept = (state_q == ST_IDLE) & start & ~flush;
    assign commit = (state_q == ST_DONE) & ~flush;

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (start) state_d = ST_CALC;
                ST_CALC: if (cnt_q == CW'(W - 1)) state_d = ST_DONE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            div_q   <= 1'b0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            dz_q    <= 1'b0;
            m_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            hi_q    <= HILO_RST;
            lo_q    <= HILO_RST;
        end else begin
            state_q <= state_d;
            if (accept) begin
                div_q <= op_is_div(op);
                sa_q  <= a_neg;
                sb_q  <= b_neg;
                dz_q  <= (src_b == '0);
                m_q   <= op_is_div(op) ? mag_b : mag_a;
                acc_q <= {{W{1'b0}}, op_is_div(op) ? mag_a : mag_b};
                cnt_q <= '0;
            end else if (state_q == ST_CALC) begin
                acc_q <= step;
                cnt_q <= cnt_q + CW'(1);
            end
            if (commit) begin
                hi_q <= div_q ? res_r : res_p[2*W-1:W];
                lo_q <= res_p[W-1:0];
            end else begin
                if (hi_wen) hi_q <= wdata;
                if (lo_wen) lo_q <= wdata;
            end
        end
    end

    assign busy  = (state_q == ST_CALC);
    assign done  = (state_q == ST_DONE) & ~flush;
    assign stall = start & ~done;
    assign hi    = hi_q;
    assign lo    = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed vectors for mul_div_unit (W=32).
// Cycle 1 is the first cycle after the accepting edge.
module tb_mul_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src_a, src_b;
    logic        flush;
    logic        hi_wen, lo_wen;
    logic [31:0] wdata;
    logic        busy, done, stall;
    logic [31:0] hi, lo;

    int n_vec = 0;
    int n_bad = 0;
    int cyc;

    always #5 clk = ~clk;

    mul_div_unit dut (
        .clk(clk), .rst(rst), .start(start), .op(op),
        .src_a(src_a), .src_b(src_b), .flush(flush),
        .hi_wen(hi_wen), .lo_wen(lo_wen), .wdata(wdata),
        .busy(busy), .done(done), .stall(stall),
        .hi(hi), .lo(lo)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Call just before the accepting edge; returns with done observed
    // (or the budget spent) and start still driven high.
    task automatic wait_done(input string tag, input logic [1:0] o);
        @(posedge clk); #1;
        cyc = 1;
        check({tag, " busy"}, 64'(busy), 64'd1);
        op    = ~o;
        src_a = ~src_a;
        src_b = 32'h0;
        @(posedge clk); #1;
        cyc++;
        check({tag, " stall"}, 64'(stall), 64'd1);
        while (!done && cyc < 60) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, " done cycle"}, 64'(cyc), 64'd33);
        check({tag, " stall@done"}, 64'(stall), 64'd0);
    endtask

    task automatic run_op(input string tag, input logic [1:0] o,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ehi, input logic [31:0] elo);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        src_a = a;
        src_b = b;
        wait_done(tag, o);
        start = 1'b0;
        @(posedge clk); #1;
        check({tag, " hi"}, 64'(hi), 64'(ehi));
        check({tag, " lo"}, 64'(lo), 64'(elo));
        check({tag, " idle"}, 64'({busy, done}), 64'd0);
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; op = 2'b00; src_a = '0; src_b = '0;
        flush = 1'b0; hi_wen = 1'b0; lo_wen = 1'b0; wdata = '0;
        #12;
        check("rst busy", 64'(busy), 64'd0);
        check("rst done", 64'(done), 64'd0);
        check("rst hi", 64'(hi), 64'd0);
        check("rst lo", 64'(lo), 64'd0);
        start = 1'b1; #1;
        check("rst stall", 64'(stall), 64'd1);
        start = 1'b0; #1;
        check("rst stall0", 64'(stall), 64'd0);
        @(negedge clk);
        rst = 1'b1;

        run_op("mult",  2'b00, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFE);
        run_op("multu", 2'b01, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE);
        run_op("div-7", 2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op("divmin", 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
        run_op("divu0", 2'b11, 32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF);
        run_op("div0",  2'b10, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF);
        run_op("multn", 2'b00, 32'h12345678, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hC962FC98);
        run_op("multu2", 2'b01, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000);
        run_op("divu",  2'b11, 32'd100, 32'd7, 32'd2, 32'd14);

        // Direct writes, then flush an op at CALC cycle 5.
        @(negedge clk);
        hi_wen = 1'b1; lo_wen = 1'b0; wdata = 32'h11111111;
        @(negedge clk);
        hi_wen = 1'b0; lo_wen = 1'b1; wdata = 32'h22222222;
        @(negedge clk);
        lo_wen = 1'b0;
        check("mthi", 64'(hi), 64'h11111111);
        check("mtlo", 64'(lo), 64'h22222222);
        start = 1'b1; op = 2'b01; src_a = 32'd5; src_b = 32'd6;
        @(posedge clk); #1;
        cyc = 1;
        repeat (4) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("flush pre busy", 64'(busy), 64'd1);
        flush = 1'b1;
        start = 1'b0;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush busy", 64'(busy), 64'd0);
        begin
            int seen = 0;
            for (int i = 0; i < 40; i++) begin
                if (done) seen++;
                @(posedge clk); #1;
            end
            check("flush done", 64'(seen), 64'd0);
        end
        check("flush hi", 64'(hi), 64'h11111111);
        check("flush lo", 64'(lo), 64'h22222222);

        // Reset mid-CALC, fresh op on release, hi_wen collides with commit.
        @(negedge clk);
        start = 1'b1; op = 2'b11; src_a = 32'd100; src_b = 32'd7;
        @(posedge clk); #1;
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("mid rst busy", 64'(busy), 64'd0);
        check("mid rst hi", 64'(hi), 64'd0);
        op = 2'b01; src_a = 32'h00010000; src_b = 32'h00010000;
        #1;
        check("mid rst stall", 64'(stall), 64'd1);
        @(negedge clk);
        rst = 1'b1;
        wait_done("rstop", 2'b01);
        hi_wen = 1'b1;
        wdata  = 32'hDEADBEEF;
        start  = 1'b0;
        @(posedge clk); #1;
        hi_wen = 1'b0;
        check("collide hi", 64'(hi), 64'h00000001);
        check("collide lo", 64'(lo), 64'h00000000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
